// File: rtl/pio_wifi_status_in_if.sv
// Avalon-MM slave bus bundle for the Wi-Fi status input PIO: register access
// signals plus the level interrupt back to the CPU.
interface pio_wifi_status_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/pio_wifi_status_in.sv
// Input PIO for Wi-Fi status pins: synchroniser, edge capture with W1C, irq mask.
// Define PIO_WIFI_STATUS_SYNC_EN for a two-flop synchroniser (otherwise one stage).
module pio_wifi_status_in #(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_wifi_status_in_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port
);

`ifdef PIO_WIFI_STATUS_SYNC_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] ARM_LAST = 2'(DEPTH);

    typedef enum logic [0:0] {
        IDLE_ARM = 1'b0,
        ARMED    = 1'b1
    } arm_state_t;

    arm_state_t       state_r;
    arm_state_t       state_s;
    logic [1:0]       arm_cnt_r;
    logic [1:0]       arm_cnt_s;

    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] raw_edge_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] edge_capture_r;
    logic [WIDTH-1:0] edge_capture_s;
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] irq_mask_s;
    logic [31:0]      readdata_r;
    logic [31:0]      readdata_s;
    logic             wr_s;
    logic             wd_unused_s;

    // Zero-extend a WIDTH-bit register value onto the 32-bit read bus.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

`ifdef PIO_WIFI_STATUS_SYNC_EN
    logic [WIDTH-1:0] meta_r;

    // Two-flop metastability synchroniser plus one-cycle delayed copy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= in_port;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end
`else
    // Single capture stage for pins already synchronous to clk.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_r <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            sync_r <= in_port;
            prev_r <= sync_r;
        end
    end
`endif

    generate
        if (EDGE_TYPE == 1) begin : g_fall
            assign raw_edge_s = ~sync_r & prev_r;
        end else if (EDGE_TYPE == 2) begin : g_any
            assign raw_edge_s = sync_r ^ prev_r;
        end else begin : g_rise
            assign raw_edge_s = sync_r & ~prev_r;
        end
    endgenerate

    // Arm state and counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE_ARM;
            arm_cnt_r <= 2'd0;
        end else begin
            state_r   <= state_s;
            arm_cnt_r <= arm_cnt_s;
        end
    end

    // Hold off edge detection until the sync chain and prev stage hold real pin data.
    always_comb begin
        state_s   = state_r;
        arm_cnt_s = arm_cnt_r;
        case (state_r)
            IDLE_ARM: begin
                arm_cnt_s = arm_cnt_r + 2'd1;
                if (arm_cnt_r == ARM_LAST) begin
                    state_s = ARMED;
                end else begin
                    state_s = IDLE_ARM;
                end
            end
            ARMED: begin
                arm_cnt_s = arm_cnt_r;
                state_s   = ARMED;
            end
            default: begin
                arm_cnt_s = 2'd0;
                state_s   = IDLE_ARM;
            end
        endcase
    end

    assign edge_s      = (state_r == ARMED) ? raw_edge_s : {WIDTH{1'b0}};
    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign wd_unused_s = ^bus.writedata;

    // Register write decode; a detected edge wins over a same-cycle W1C clear.
    always_comb begin
        edge_capture_s = edge_capture_r;
        irq_mask_s     = irq_mask_r;
        if (wr_s && (bus.address == 2'd3)) begin
            edge_capture_s = edge_capture_r & ~bus.writedata[WIDTH-1:0];
        end else begin
            edge_capture_s = edge_capture_r;
        end
        if (wr_s && (bus.address == 2'd2)) begin
            irq_mask_s = bus.writedata[WIDTH-1:0];
        end else begin
            irq_mask_s = irq_mask_r;
        end
        edge_capture_s = edge_capture_s | edge_s;
    end

    // Read mux.
    always_comb begin
        readdata_s = 32'd0;
        case (bus.address)
            2'd0:    readdata_s = zext(sync_r);
            2'd1:    readdata_s = 32'd0;
            2'd2:    readdata_s = zext(irq_mask_r);
            2'd3:    readdata_s = zext(edge_capture_r);
            default: readdata_s = 32'd0;
        endcase
    end

    // Software-visible registers and registered read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_capture_r <= {WIDTH{1'b0}};
            irq_mask_r     <= {WIDTH{1'b0}};
            readdata_r     <= 32'd0;
        end else begin
            edge_capture_r <= edge_capture_s;
            irq_mask_r     <= irq_mask_s;
            if (bus.chipselect) begin
                readdata_r <= readdata_s;
            end else begin
                readdata_r <= readdata_r;
            end
        end
    end

    assign bus.readdata = readdata_r;
    assign bus.irq      = |(edge_capture_r & irq_mask_r);

endmodule
